e_mdu: RTL and testbench

Execute-stage multiply/divide unit. It sits beside the ALU, consumes the same forwarded register operands (rs value and rt value), and owns the architectural HI/LO registers. Multi-cycle MULT/MULTU/DIV/DIVU run behind a Busy flag that the hazard unit uses to stall the pipeline. MFHI/MFLO/MTHI/MTLO access HI/LO directly. A request-cancel input suppresses new side effects when the instruction in E is flushed by an exception or interrupt.

---
 rtl/e_mdu.sv | 157 +++++++++++++++
 tb/tb_e_mdu.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// ============================================================================
// Module   : e_mdu
// Function : Execute-stage multiply/divide unit. It owns the HI/LO registers
//            and runs multi-cycle MULT/DIV operations behind E_Busy.
// Revision : 1.0
// ============================================================================
`default_nettype none

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_Req,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W    = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
  localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             dz_q, dz_d;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_accept;
  logic        w_mt_ok;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_div_b;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_mul = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
  assign w_is_div = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_signed = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_DIV);
  assign w_accept = E_Start && !E_Req && !E_Busy && (w_is_mul || w_is_div);
  assign w_mt_ok  = !E_Req && !E_Busy;

  // Multiply: sign/zero-extend to 64 bits; the low 64 bits of the product
  // are correct for both signed and unsigned operands.
  assign w_a_ext = {{32{w_signed & E_A[31]}}, E_A};
  assign w_b_ext = {{32{w_signed & E_B[31]}}, E_B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Divide on magnitudes, then restore signs. The 0x80000000 / -1 case falls
  // out naturally: magnitude quotient 0x80000000 negates to itself.
  assign w_a_neg = w_signed & E_A[31];
  assign w_b_neg = w_signed & E_B[31];
  assign w_a_mag = w_a_neg ? (~E_A + 32'd1) : E_A;
  assign w_b_mag = w_b_neg ? (~E_B + 32'd1) : E_B;
  assign w_div_b = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q_mag = w_a_mag / w_div_b;
  assign w_r_mag = w_a_mag % w_div_b;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_res_hi = w_is_mul ? w_prod[63:32] : w_rem;
  assign w_res_lo = w_is_mul ? w_prod[31:0]  : w_quot;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    dz_d      = dz_q;

    if (w_accept) begin
      cnt_d     = w_is_mul ? C_MULT_CNT : C_DIV_CNT;
      pend_hi_d = w_res_hi;
      pend_lo_d = w_res_lo;
      dz_d      = w_is_div && (E_B == 32'd0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if ((cnt_q == CNT_W'(1)) && !dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end

    // Moves only happen when idle, so they never collide with a commit.
    if (w_mt_ok && (E_MDUOp == OP_MTHI)) begin
      hi_d = E_A;
    end
    if (w_mt_ok && (E_MDUOp == OP_MTLO)) begin
      lo_d = E_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      dz_q      <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      dz_q      <= dz_d;
    end
  end

  assign E_Busy = (cnt_q != '0);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

  always_comb begin
    E_MDUOut = 32'd0;
    if (E_MDUOp == OP_MFHI) begin
      E_MDUOut = hi_q;
    end else if (E_MDUOp == OP_MFLO) begin
      E_MDUOut = lo_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module   : tb_e_mdu
// Function : Self-checking bench for e_mdu against an arithmetic HI/LO model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Req;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDUOut;

  int n_checks;
  int n_errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_MDUOp  (E_MDUOp),
    .E_Start  (E_Start),
    .E_A      (E_A),
    .E_B      (E_B),
    .E_Req    (E_Req),
    .E_Busy   (E_Busy),
    .E_HI     (E_HI),
    .E_LO     (E_LO),
    .E_MDUOut (E_MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: architectural HI/LO after an op, from plain integer arithmetic.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin
        sq = sa * sb;
        m_hi = sq[63:32];
        m_lo = sq[31:0];
      end
      4'd2: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32];
        m_lo = up[31:0];
      end
      4'd3: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  task automatic idle_inputs();
    E_MDUOp = 4'd0;
    E_Start = 1'b0;
    E_A     = 32'd0;
    E_B     = 32'd0;
    E_Req   = 1'b0;
  endtask

  // Drives a start at the current negedge and checks busy window and result.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n;
    int bad_busy;
    n = (op <= 4'd2) ? MULT_N : DIV_N;
    E_MDUOp = op;
    E_Start = 1'b1;
    E_A     = a;
    E_B     = b;
    model_op(op, a, b);
    @(negedge clk);
    idle_inputs();
    bad_busy = 0;
    for (int i = 1; i <= n; i++) begin
      if (E_Busy !== 1'b1) bad_busy = i;
      @(negedge clk);
    end
    n_checks++;
    if (bad_busy != 0) begin
      n_errors++;
      $display("FAIL %s busy_window: busy low at cycle t+%0d, required high t+1..t+%0d", name, bad_busy, n);
    end
    n_checks++;
    if (E_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy_end: got %b, expected 0", name, E_Busy);
    end
    n_checks++;
    if (E_HI !== m_hi || E_LO !== m_lo) begin
      n_errors++;
      $display("FAIL %s result a=%h b=%h: got HI=%h LO=%h, expected HI=%h LO=%h",
               name, a, b, E_HI, E_LO, m_hi, m_lo);
    end
    E_MDUOp = 4'd5;
    #1;
    n_checks++;
    if (E_MDUOut !== m_hi) begin
      n_errors++;
      $display("FAIL %s mfhi: got %h, expected %h", name, E_MDUOut, m_hi);
    end
    E_MDUOp = 4'd6;
    #1;
    n_checks++;
    if (E_MDUOut !== m_lo) begin
      n_errors++;
      $display("FAIL %s mflo: got %h, expected %h", name, E_MDUOut, m_lo);
    end
    E_MDUOp = 4'd0;
  endtask

  task automatic do_move(input logic [3:0] op, input logic [31:0] a, input logic req);
    E_MDUOp = op;
    E_A     = a;
    E_Req   = req;
    if (!req) begin
      if (op == 4'd7) m_hi = a;
      if (op == 4'd8) m_lo = a;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    n_checks++;
    if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0 || E_MDUOut !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_state: got busy=%b HI=%h LO=%h OUT=%h, expected 0/0/0/0",
               E_Busy, E_HI, E_LO, E_MDUOut);
    end
  endtask

  task automatic test_directed();
    run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0003, "mult_neg1x3");
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0003, "multu_ffx3");
    run_op(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2");
    run_op(4'd4, 32'h0000_0007, 32'h0000_0002, "divu_7_2");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
  endtask

  task automatic test_div_zero();
    do_move(4'd7, 32'h0000_0011, 1'b0);
    do_move(4'd8, 32'h0000_0022, 1'b0);
    run_op(4'd3, 32'h1234_5678, 32'd0, "div_by_zero");
    run_op(4'd4, 32'hDEAD_BEEF, 32'd0, "divu_by_zero");
  endtask

  task automatic test_move_and_req();
    do_move(4'd7, 32'h0000_ABCD, 1'b0);
    E_MDUOp = 4'd5;
    #1;
    n_checks++;
    if (E_MDUOut !== 32'h0000_ABCD) begin
      n_errors++;
      $display("FAIL mthi_mfhi: got %h, expected 0000abcd", E_MDUOut);
    end
    E_MDUOp = 4'd0;
    #1;
    n_checks++;
    if (E_MDUOut !== 32'd0) begin
      n_errors++;
      $display("FAIL mduout_none: got %h, expected 0", E_MDUOut);
    end
    do_move(4'd8, 32'h5555_AAAA, 1'b1);
    n_checks++;
    if (E_LO !== m_lo) begin
      n_errors++;
      $display("FAIL mtlo_req: got LO=%h, expected %h", E_LO, m_lo);
    end
    E_MDUOp = 4'd1;
    E_Start = 1'b1;
    E_A     = 32'd7;
    E_B     = 32'd9;
    E_Req   = 1'b1;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (E_Busy !== 1'b0) begin
      n_errors++;
      $display("FAIL start_req: got busy=%b, expected 0", E_Busy);
    end
    repeat (MULT_N + 1) @(negedge clk);
    n_checks++;
    if (E_HI !== m_hi || E_LO !== m_lo) begin
      n_errors++;
      $display("FAIL start_req_nocommit: got HI=%h LO=%h, expected HI=%h LO=%h", E_HI, E_LO, m_hi, m_lo);
    end
  endtask

  task automatic test_start_while_busy();
    E_MDUOp = 4'd1;
    E_Start = 1'b1;
    E_A     = 32'd2;
    E_B     = 32'd3;
    model_op(4'd1, 32'd2, 32'd3);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    E_MDUOp = 4'd4;
    E_Start = 1'b1;
    E_A     = 32'd9;
    E_B     = 32'd4;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    n_checks++;
    if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd6) begin
      n_errors++;
      $display("FAIL start_while_busy: got busy=%b HI=%h LO=%h, expected 0/0/6", E_Busy, E_HI, E_LO);
    end
    repeat (DIV_N + 2) @(negedge clk);
    n_checks++;
    if (E_HI !== 32'd0 || E_LO !== 32'd6) begin
      n_errors++;
      $display("FAIL ignored_start_late: got HI=%h LO=%h, expected 0/6", E_HI, E_LO);
    end
  endtask

  task automatic test_reset_mid_op();
    do_move(4'd7, 32'hCAFE_0001, 1'b0);
    E_MDUOp = 4'd2;
    E_Start = 1'b1;
    E_A     = 32'h0001_2345;
    E_B     = 32'h0000_0100;
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    n_checks++;
    if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_op: got busy=%b HI=%h LO=%h, expected 0/0/0", E_Busy, E_HI, E_LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (MULT_N + 3) @(negedge clk);
    n_checks++;
    if (E_Busy !== 1'b0 || E_HI !== 32'd0 || E_LO !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_late_commit: got busy=%b HI=%h LO=%h, expected 0/0/0", E_Busy, E_HI, E_LO);
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'd2, 32'h0000_1000, 32'h0001_0000, "b2b_first");
    run_op(4'd3, 32'h0000_0064, 32'hFFFF_FFF9, "b2b_second");
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, "b2b_third");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 24; i++) begin
      op  = 4'($urandom_range(1, 4));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel < 5) b = b >> $urandom_range(8, 28);
      if ((i % 5) == 4) do_move(4'd8, $urandom, 1'b0);
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    reset    = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_move_and_req();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
